// File: rtl/store_buffer.sv
// Posted-write FIFO between the store formatter and the memory write port, with
// per-byte load forwarding. Define SB_MERGE_EN to combine stores into the newest entry.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              in_addr,
   input  logic [31:0]              in_data,
   input  logic [3:0]               in_byteen,
   output logic                     in_stall,
   output logic                     mem_valid,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_byteen,
   input  logic                     mem_ready,
   input  logic [31:0]              ld_addr,
   output logic [31:0]              ld_fwd_data,
   output logic [3:0]               ld_fwd_mask,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [29:0]   r_addr   [DEPTH];
   logic [31:0]   r_data   [DEPTH];
   logic [3:0]    r_byteen [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;

   logic w_full;
   logic w_empty;
   logic w_store;
   logic w_merge_hit;
   logic w_push;
   logic w_pop;
   logic w_unused;

   assign w_unused = ^{in_addr[1:0], ld_addr[1:0]};

`ifdef SB_MERGE_EN
   logic [AW-1:0] w_tail_prev;
   assign w_tail_prev = r_tail - 1'b1;
   // count >= 2 keeps the newest entry distinct from the head being presented
   assign w_merge_hit = w_store && (r_count >= (AW+1)'(2)) &&
                        (r_addr[w_tail_prev] == in_addr[31:2]);
`else
   assign w_merge_hit = 1'b0;
`endif

   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign w_store  = (in_byteen != 4'b0000);
   assign in_stall = w_store && w_full && !w_merge_hit;
   assign w_push   = w_store && !w_full && !w_merge_hit;
   assign w_pop    = !w_empty && mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage carries no reset; occupancy alone decides validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail]   <= in_addr[31:2];
         r_data[r_tail]   <= in_data;
         r_byteen[r_tail] <= in_byteen;
      end
`ifdef SB_MERGE_EN
      if (w_merge_hit) begin
         r_byteen[w_tail_prev] <= r_byteen[w_tail_prev] | in_byteen;
         for (int b = 0; b < 4; b++) begin
            if (in_byteen[b]) r_data[w_tail_prev][8*b +: 8] <= in_data[8*b +: 8];
         end
      end
`endif
   end

   assign mem_valid  = !w_empty;
   assign mem_addr   = w_empty ? 32'h0 : {r_addr[r_head], 2'b00};
   assign mem_wdata  = w_empty ? 32'h0 : r_data[r_head];
   assign mem_byteen = w_empty ? 4'h0  : r_byteen[r_head];
   assign count      = r_count;

   // Walk oldest to youngest so the youngest matching entry overwrites each lane
   always_comb begin
      logic [AW-1:0] w_idx;
      ld_fwd_data = 32'h0;
      ld_fwd_mask = 4'h0;
      w_idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + AW'(k);
         if (((AW+1)'(k) < r_count) && (r_addr[w_idx] == ld_addr[31:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (r_byteen[w_idx][b]) begin
                  ld_fwd_mask[b]        = 1'b1;
                  ld_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write queue between the byte-enable store formatter and the data-memory/bridge write port in the M stage. It accepts word-aligned stores: word address, 32-bit lane-positioned data and 4-bit byte write mask. Stores drain in order through a valid/ready handshake, so a slow device no longer stalls every store. It also returns per-byte forwarded data for loads that hit pending stores, and raises a stall when it cannot accept a store.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- in_addr  in  32  store byte address; bits [1:0] are ignored, and only [31:2] is stored.
- in_data  in  32  store data, already placed in its byte lanes.
- in_byteen  in  4  byte write mask; 4'b0000 means no store this cycle.
- in_stall  out  1  combinational; a non-zero in_byteen is not accepted this cycle.
- mem_valid  out  1  the head entry is presented.
- mem_addr  out  32  {head word address, 2'b00}.
- mem_wdata  out  32  head data.
- mem_byteen  out  4  head byte mask.
- mem_ready  in  1  the memory side consumes the head entry this cycle.
- ld_addr  in  32  load byte address to check against pending stores.
- ld_fwd_data  out  32  combinational forwarded bytes; bytes not covered are 0.
- ld_fwd_mask  out  4  combinational; bit i set means byte lane i is supplied by the buffer.
- count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular FIFO with head and tail pointers and an occupancy counter. full = (count == DEPTH); empty = (count == 0).
- Push: occurs when in_byteen != 0 and in_stall == 0. The entry {in_addr[31:2], in_data, in_byteen} is written at the tail, and the tail wraps modulo DEPTH.
- in_stall = (in_byteen != 0) && full && !merge_hit. A pop in the same cycle does not free a slot for the push, so a full buffer stalls even when mem_ready is high.
- Pop: occurs when mem_valid && mem_ready. The head advances and wraps modulo DEPTH.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- mem_valid = !empty. mem_addr, mem_wdata and mem_byteen are the head entry's fields, driven directly from storage. They are 0 when empty.
- Head fields must not change while mem_valid is high and mem_ready is low.
- Forwarding is computed for each byte lane i independently:
  - Scan only valid entries, including the head even if it pops this cycle.
  - An entry qualifies when its word address equals ld_addr[31:2] and its byteen[i] is set.
  - Of the qualifying entries, the youngest one supplies byte i.
  - The store being pushed in the same cycle is not visible to forwarding.
- The block does not check alignment; misaligned-store exceptions are resolved upstream.

## Timing
- Reset values: count 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_byteen 0, in_stall 0 (when in_byteen == 0), ld_fwd_mask 0, ld_fwd_data 0. Entry contents are don't-care after reset.
- Reset wins over a push or pop in the same cycle; any queued stores are discarded.
- Latency: a store pushed at edge N into an empty buffer drives mem_valid = 1 during cycle N+1.
- Throughput: one push and one pop per cycle.
- Forwarding and stall paths are purely combinational from the current state and inputs. There is no registered output on these paths.

## Configuration
- SB_MERGE_EN defined: write combining is enabled.
  - merge_hit = (in_byteen != 0) && count >= 2 && the tail-1 entry's word address equals in_addr[31:2].
  - On merge_hit no new entry is allocated. The tail-1 entry takes byteen |= in_byteen, and each of its bytes with in_byteen set takes the new data.
  - Merging is allowed when the buffer is full, and it does not assert in_stall.
  - The head entry is never merged into, which keeps the handshake stable.
- SB_MERGE_EN undefined: merge_hit is 0, and every store allocates an entry.

## Test plan
- After reset: push addr 0x0000_1004, data 0x1122_3344, byteen 4'b1111 with mem_ready=0.
  - Next cycle: mem_valid=1, mem_addr=0x0000_1004, count=1.
  - Raise mem_ready for one cycle: afterwards count=0 and mem_valid=0.
- Fill DEPTH=4 with distinct words while mem_ready=0, then push a fifth store to a new word.
  - Required: in_stall=1, and count stays 4.
  - Raise mem_ready with the push still present: a pop occurs, in_stall stays 1 that cycle, and the push is accepted the next cycle.
- Forwarding with youngest priority:
  - Pending stores: 0x2000 data 0x0000_00AA byteen 0001, then 0x2000 data 0x0000_BB00 byteen 0010, then 0x2000 data 0x0000_00CC byteen 0001.
  - Set ld_addr=0x2002.
  - Required: ld_fwd_mask=4'b0011 and ld_fwd_data=0x0000_BBCC.
- Wrap-around: push and pop continuously for 10 stores at addresses 0x3000+4k.
  - Required: the memory side sees all 10 in order with matching data.
- Reset mid-operation: with count=3, assert reset together with a push and mem_ready=1.
  - Required: after the edge, count=0 and mem_valid=0.
- With SB_MERGE_EN:
  - Pending stores: A=0x4000 byteen 1111, then B=0x4008 byteen 0001 data 0x0000_0011.
  - Push 0x400B with data 0x2200_0000 and byteen 1000.
  - Required: count stays 2, and the B entry becomes byteen 1001 with data 0x2200_0011.
- Without SB_MERGE_EN, the same stimulus gives count=3.
